ssd_driver: RTL and testbench

Sequential seven-segment display driver for the 4-digit board display. Consumes the 13-bit value chosen by the debug-view selector, converts it to four BCD digits with an iterative shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto active-low anode and cathode pins. It sits between the selector output and the top-level display pins.

---
 rtl/ssd_pkg.sv | 51 +++++
 rtl/ssd_driver_if.sv | 21 ++
 rtl/bin2bcd_seq.sv | 80 ++++++++
 rtl/ssd_driver.sv | 68 ++++++
 tb/tb_ssd_driver.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/ssd_pkg.sv
// Shared constants, converter state and segment patterns
// for the four-digit seven-segment display driver.
package ssd_pkg;

    localparam int DIGITS       = 4;
    localparam int VALUE_W      = 13;
    localparam int BCD_W        = 16;
    localparam int SHIFT_CYCLES = 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } conv_state_t;

    // Active-low cathodes ordered {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/ssd_driver_if.sv
// Selector-side and pin-side signals of the display driver.
interface ssd_driver_if;
    import ssd_pkg::*;

    logic [VALUE_W-1:0] value;
    logic               hold;
    logic [DIGITS-1:0]  anode;
    logic [6:0]         seg;
    logic               bcd_valid;

    modport master (
        output value, hold,
        input  anode, seg, bcd_valid
    );

    modport slave (
        input  value, hold,
        output anode, seg, bcd_valid
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter,
// one bit per cycle, 15-cycle conversion period.
module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] value,
    input  logic               hold,
    output logic [BCD_W-1:0]   bcd,
    output logic               valid
);

    conv_state_t        state_q, state_d;
    logic [VALUE_W-1:0] bin_q;
    logic [BCD_W-1:0]   acc_q;
    logic [BCD_W-1:0]   acc_adj;
    logic [3:0]         cnt_q;
    logic               load, shift, latch;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        latch   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!hold) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (cnt_q == 4'(SHIFT_CYCLES - 1))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                latch   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_adj = '0;
        for (int i = 0; i < BCD_W / 4; i++)
            acc_adj[4*i +: 4] = add3(acc_q[4*i +: 4]);
    end

    // Display register only changes on DONE, so an abort leaves it clean
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            bcd   <= '0;
        end else begin
            if (load) begin
                bin_q <= value;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (shift) begin
                {acc_q, bin_q} <= {acc_adj[BCD_W-2:0], bin_q, 1'b0};
                cnt_q          <= cnt_q + 4'd1;
            end
            if (latch)
                bcd <= acc_q;
        end
    end

    assign valid = (state_q == ST_DONE);

endmodule

// File: rtl/ssd_driver.sv
// Four-digit multiplexed seven-segment driver with BCD converter.
// SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module ssd_driver
    import ssd_pkg::*;
#(
    parameter int REFRESH_BITS = 18
) (
    input logic         clk,
    input logic         rst,
    ssd_driver_if.slave bus
);

    logic [BCD_W-1:0]        disp;
    logic                    conv_valid;
    logic [REFRESH_BITS-1:0] cnt_q;
    logic [1:0]              idx;
    logic [3:0]              digit;
    logic                    blank;
    logic [6:0]              seg_d, seg_q;
    logic [DIGITS-1:0]       anode_d, anode_q;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .value (bus.value),
        .hold  (bus.hold),
        .bcd   (disp),
        .valid (conv_valid)
    );

    assign idx   = cnt_q[REFRESH_BITS-1 -: 2];
    assign digit = disp[{idx, 2'b00} +: 4];

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // A digit blanks only when it and every higher digit are zero
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd3:    blank = (disp[15:12] == 4'd0);
            2'd2:    blank = (disp[15:8] == 8'd0);
            2'd1:    blank = (disp[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign seg_d   = blank ? SEG_BLANK : seg_decode(digit);
    assign anode_d = ~(4'b0001 << idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            anode_q <= 4'b1110;
            seg_q   <= SEG_0;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.anode     = anode_q;
    assign bus.seg       = seg_q;
    assign bus.bcd_valid = conv_valid;

endmodule

// File: tb/tb_ssd_driver.sv
// Randomized bench for ssd_driver against a cycle-schedule
// and decimal-arithmetic model of the display.
module tb_ssd_driver;

    localparam int RB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ssd_driver_if bus ();

    ssd_driver #(.REFRESH_BITS(RB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] pat [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    int pw [4] = '{1, 10, 100, 1000};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(int v, int pos);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (pos > 0 && v < pw[pos]) return 7'b1111111;
`endif
        return pat[(v / pw[pos]) % 10];
    endfunction

    // cyc counts cycles since the last edge that saw rst high
    int cyc = 0;
    bit rst_q = 1'b0;

    always @(posedge clk) begin
        rst_q <= rst;
        cyc   <= rst ? 0 : cyc + 1;
    end

    bit         armed = 1'b0;
    bit         busy = 1'b0;
    int         disp = 0, seg_disp = 0, cap = 0, done_cyc = 0, pidx;
    logic [3:0] exp_an;
    logic [6:0] exp_sg;

    always @(negedge clk) begin
        if (rst_q) armed = 1'b1;
        if (armed) begin
            if (rst_q) begin
                busy     = 1'b0;
                disp     = 0;
                seg_disp = 0;
            end
            if (busy && cyc == done_cyc + 1) begin
                disp = cap;
                busy = 1'b0;
            end
            chk("bcd_valid", 32'(bus.bcd_valid),
                32'(busy && cyc == done_cyc));
            if (cyc == 0) begin
                exp_an = 4'b1110;
                exp_sg = 7'b0000001;
            end else begin
                pidx   = ((cyc - 1) % (1 << RB)) >> (RB - 2);
                exp_an = ~(4'b0001 << pidx);
                exp_sg = exp_seg(seg_disp, pidx);
            end
            chk("anode", 32'(bus.anode), 32'(exp_an));
            chk("seg", 32'(bus.seg), 32'(exp_sg));
            chk("one_anode_low", $countones(~bus.anode), 1);
            if (!rst && !busy && !bus.hold) begin
                cap      = int'(bus.value);
                done_cyc = cyc + 14;
                busy     = 1'b1;
            end
            seg_disp = disp;
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    initial begin
        bus.value = 13'd8191;
        bus.hold  = 1'b0;
        rst       = 1'b1;
        step(3);
        rst = 1'b0;
        step(45);

        bus.value = 13'd1234;
        step(20);
        bus.hold  = 1'b1;
        bus.value = 13'd5678;
        step(40);
        bus.hold = 1'b0;
        step(35);

        rst       = 1'b1;
        bus.value = 13'd999;
        step(2);
        rst = 1'b0;
        step(6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(40);

        bus.value = 13'd42;
        step(40);
        bus.value = 13'd0;
        step(40);
        bus.value = 13'd7;
        step(40);

        for (int i = 0; i < 12; i++) begin
            bus.value = 13'($urandom_range(0, 8191));
            bus.hold  = ($urandom_range(0, 3) == 0);
            step($urandom_range(5, 40));
        end
        bus.hold = 1'b0;
        step(40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
